// File: rtl/stm_sweep.sv
// stm_sweep: parametrised sweep generator that moves x between runtime
// bounds lo and hi by a runtime step, in bounce (triangle) or sawtooth mode.
// Endpoint events produce registered one-cycle peak/floor pulses.
// Optional feature: define STM_SWEEP_DWELL_EN to hold x at each bounce
// endpoint for DWELL enabled cycles before turning around.
module stm_sweep #(
    parameter int WIDTH = 4,
    parameter int DWELL = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_dir,
    output logic [WIDTH-1:0] x,
    output logic             dir,
    output logic             peak,
    output logic             floor
);

`ifdef STM_SWEEP_DWELL_EN
    typedef enum logic [1:0] {
        DOWN = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DWELL > 0) ? DWELL - 1 : 0);
`else
    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } state_t;

    localparam int dwell_unused = DWELL;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             peak_q, peak_d;
    logic             floor_q, floor_d;

`ifdef STM_SWEEP_DWELL_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_top_q, hold_top_d;
`endif

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_diff;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] down_val;
    logic [WIDTH-1:0] load_clamped;

    // Arithmetic helpers: zero step acts as one, sums carry an extra bit so
    // the clamp catches overflow and the borrow bit catches underflow.
    always_comb begin
        step_eff  = (step == '0) ? WIDTH'(1) : step;
        up_sum    = {1'b0, x_q} + {1'b0, step_eff};
        down_diff = {1'b0, x_q} - {1'b0, step_eff};
        up_val    = (up_sum >= {1'b0, hi}) ? hi : up_sum[WIDTH-1:0];
        down_val  = (down_diff[WIDTH] || (down_diff[WIDTH-1:0] <= lo)) ? lo : down_diff[WIDTH-1:0];
        if (load_val < lo) begin
            load_clamped = lo;
        end else if (load_val > hi) begin
            load_clamped = hi;
        end else begin
            load_clamped = load_val;
        end
    end

    // State register: all sweep state, cleared asynchronously by low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= DOWN;
            x_q        <= '0;
            peak_q     <= 1'b0;
            floor_q    <= 1'b0;
`ifdef STM_SWEEP_DWELL_EN
            cnt_q      <= '0;
            hold_top_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            peak_q     <= peak_d;
            floor_q    <= floor_d;
`ifdef STM_SWEEP_DWELL_EN
            cnt_q      <= cnt_d;
            hold_top_q <= hold_top_d;
`endif
        end
    end

    // Next-state logic: load beats enable; enable runs bound recovery first,
    // then the per-mode sweep step and endpoint turnarounds.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        peak_d     = 1'b0;
        floor_d    = 1'b0;
`ifdef STM_SWEEP_DWELL_EN
        cnt_d      = cnt_q;
        hold_top_d = hold_top_q;
`endif
        if (load) begin
            x_d     = load_clamped;
            state_d = load_dir ? UP : DOWN;
`ifdef STM_SWEEP_DWELL_EN
            cnt_d   = '0;
`endif
        end else if (en) begin
            if (lo >= hi) begin
                x_d = lo;
            end else if (x_q < lo) begin
                x_d = lo;
            end else if (x_q > hi) begin
                x_d = hi;
            end else begin
                case (state_q)
                    UP: begin
                        if (x_q == hi) begin
                            if (mode) begin
                                x_d    = lo;
                                peak_d = 1'b1;
                            end else begin
`ifdef STM_SWEEP_DWELL_EN
                                if (DWELL > 0) begin
                                    state_d    = HOLD;
                                    hold_top_d = 1'b1;
                                    cnt_d      = '0;
                                end else begin
                                    state_d = DOWN;
                                    peak_d  = 1'b1;
                                end
`else
                                state_d = DOWN;
                                peak_d  = 1'b1;
`endif
                            end
                        end else begin
                            x_d = up_val;
                        end
                    end
                    DOWN: begin
                        if (mode) begin
                            state_d = UP;
                        end else if (x_q == lo) begin
`ifdef STM_SWEEP_DWELL_EN
                            if (DWELL > 0) begin
                                state_d    = HOLD;
                                hold_top_d = 1'b0;
                                cnt_d      = '0;
                            end else begin
                                state_d = UP;
                                floor_d = 1'b1;
                            end
`else
                            state_d = UP;
                            floor_d = 1'b1;
`endif
                        end else begin
                            x_d = down_val;
                        end
                    end
`ifdef STM_SWEEP_DWELL_EN
                    HOLD: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (hold_top_q) begin
                                state_d = DOWN;
                                peak_d  = 1'b1;
                            end else begin
                                state_d = UP;
                                floor_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        state_d = DOWN;
                    end
                endcase
            end
        end
    end

    // Output logic: everything comes straight from registers.
    always_comb begin
        x     = x_q;
        dir   = (state_q == UP);
        peak  = peak_q;
        floor = floor_q;
    end

endmodule

// File: tb/tb_stm_sweep.sv
// tb_stm_sweep: directed self-checking bench for stm_sweep (WIDTH=4, DWELL=2).
// Bounce sequences differ with STM_SWEEP_DWELL_EN, so those steps follow it.
module tb_stm_sweep;

    logic       clock;
    logic       reset;
    logic       en;
    logic       mode;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] step;
    logic       load;
    logic [3:0] load_val;
    logic       load_dir;
    logic [3:0] x;
    logic       dir;
    logic       peak;
    logic       floor;

    int totalChecks = 0;
    int badChecks   = 0;

    stm_sweep #(.WIDTH(4), .DWELL(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .load_dir (load_dir),
        .x        (x),
        .dir      (dir),
        .peak     (peak),
        .floor    (floor)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive the controls, take one rising edge, then settle 1 time unit.
    task automatic applyStimulus(input logic iEn, input logic iMode,
                                 input logic [3:0] iLo, input logic [3:0] iHi,
                                 input logic [3:0] iStep, input logic iLoad,
                                 input logic [3:0] iLoadVal, input logic iLoadDir);
        en       = iEn;
        mode     = iMode;
        lo       = iLo;
        hi       = iHi;
        step     = iStep;
        load     = iLoad;
        load_val = iLoadVal;
        load_dir = iLoadDir;
        @(posedge clock);
        #1;
    endtask

    // Compare all outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [3:0] expX,
                               input logic expDir, input logic expPeak, input logic expFloor);
        totalChecks++;
        assert ({x, dir, peak, floor} === {expX, expDir, expPeak, expFloor}) else begin
            badChecks++;
            $display("[TB] FAIL %s: got x=%0d dir=%0b peak=%0b floor=%0b, want x=%0d dir=%0b peak=%0b floor=%0b",
                     tag, x, dir, peak, floor, expX, expDir, expPeak, expFloor);
            $error("[TB] check %s: got x=%0d want x=%0d", tag, x, expX);
        end
    endtask

    logic [3:0] seqX   [9] = '{4'd3, 4'd7, 4'd11, 4'd12, 4'd12, 4'd8, 4'd4, 4'd3, 4'd3};
    logic       seqDir [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       seqPk  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       seqFl  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [3:0] dwX    [14] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       dwDir  [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       dwPk   [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       dwFl   [14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Directed sequence: reset, bounce sweeps, bounds handling, sawtooth,
    // load clamping and asynchronous reset mid-sweep.
    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        lo       = 4'd0;
        hi       = 4'd15;
        step     = 4'd1;
        load     = 1'b0;
        load_val = 4'd0;
        load_dir = 1'b0;
        #2;
        checkOutput("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

`ifndef STM_SWEEP_DWELL_EN
        // Full-range bounce, step 1: floor at edge 1, peak at 17, floor at 33.
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("first_floor", 4'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b0);
            checkOutput("count_up", 4'(i), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("peak_15", 4'd15, 1'b0, 1'b1, 1'b0);
        for (int i = 14; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b0);
            checkOutput("count_down", 4'(i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("second_floor", 4'd0, 1'b1, 1'b0, 1'b1);

        // lo=3 hi=12 step=4: first edge recovers x from 0 up to lo.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd3, 4'd12, 4'd4, 1'b0, 4'd0, 1'b0);
            checkOutput("step4_seq", seqX[i], seqDir[i], seqPk[i], seqFl[i]);
        end

        // Enable low holds x and drops the pulse.
        applyStimulus(1'b0, 1'b0, 4'd3, 4'd12, 4'd4, 1'b0, 4'd0, 1'b0);
        checkOutput("en_low_hold", 4'd3, 1'b1, 1'b0, 1'b0);

        // Degenerate bounds force x to lo without touching state.
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd5, 4'd4, 1'b0, 4'd0, 1'b0);
        checkOutput("degenerate", 4'd5, 1'b1, 1'b0, 1'b0);

        // x above hi recovers to hi; step 0 behaves as 1.
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("recover_hi", 4'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("step0_peak", 4'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("step0_down", 4'd2, 1'b0, 1'b0, 1'b0);
`else
        // Dwell bounce lo=0 hi=3: two hold cycles at each end, period 12.
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("dwell_enter", 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
            checkOutput("dwell_seq", dwX[i], dwDir[i], dwPk[i], dwFl[i]);
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
            checkOutput("dwell_up2", 4'(i), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("dwell_hold0", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("dwell_frozen", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("dwell_frozen", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("dwell_hold1", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("dwell_peak", 4'd3, 1'b0, 1'b1, 1'b0);
`endif

        // Sawtooth lo=2 hi=5 step=1: 2,3,4,5,2(peak), state stays UP.
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 1'b1, 4'd2, 1'b1);
        checkOutput("saw_load", 4'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 1'b0, 4'd0, 1'b0);
            checkOutput("saw_up", 4'(i), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("saw_wrap", 4'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("saw_after", 4'd3, 1'b1, 1'b0, 1'b0);

        // Sawtooth in DOWN flips to UP with x held.
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 1'b1, 4'd4, 1'b0);
        checkOutput("saw_load_dn", 4'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("saw_dn_flip", 4'd4, 1'b1, 1'b0, 1'b0);

        // Load clamps to hi and to lo; load works with enable low too.
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd10, 4'd1, 1'b1, 4'd14, 1'b0);
        checkOutput("load_clamp_hi", 4'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd2, 4'd10, 4'd1, 1'b1, 4'd0, 1'b1);
        checkOutput("load_clamp_lo", 4'd2, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while x=9 going up, checked between edges.
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b1, 4'd9, 1'b1);
        checkOutput("pre_reset", 4'd9, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b0);
`ifndef STM_SWEEP_DWELL_EN
        checkOutput("post_reset", 4'd0, 1'b1, 1'b0, 1'b1);
`else
        checkOutput("post_reset", 4'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/stm_sweep.md
# stm_sweep

Parametrised successor to the 4-bit up/down bounce counter. Produces a WIDTH-bit sweep value that moves between runtime bounds `lo` and `hi` by a runtime `step`, in either bounce (triangle) or sawtooth mode. Supports enable, synchronous load, and registered endpoint pulses. Sits in the same lab design as a waveform/pattern source driving displays or PWM comparators.

## Interface
- `WIDTH`, 4: width of `x`, `lo`, `hi`, `step`, `load_val`.
- `DWELL`, 2: extra hold cycles at each endpoint. Used only when `STM_SWEEP_DWELL_EN` is defined.
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low. Low forces the reset state immediately.
- `en`  in  1: advance enable. Low holds all state; pulses deassert.
- `mode`  in  1: 0 = bounce, 1 = sawtooth (up only, wrap to `lo`).
- `lo`  in  WIDTH: lower bound, unsigned.
- `hi`  in  WIDTH: upper bound, unsigned.
- `step`  in  WIDTH: increment magnitude; 0 is treated as 1.
- `load`  in  1: synchronous load strobe; takes priority over `en`.
- `load_val`  in  WIDTH: value for load.
- `load_dir`  in  1: direction after load (1 = up).
- `x`  out  WIDTH: sweep value (registered).
- `dir`  out  1: 1 while state is UP.
- `peak`  out  1: one-cycle pulse on each top-endpoint event.
- `floor`  out  1: one-cycle pulse on each bottom-endpoint event.

## Operation
- States: DOWN, UP, HOLD (HOLD exists only with the macro).
- Reset values: `x`=0, state DOWN, `dir`=0, `peak`=0, `floor`=0, dwell counter 0.
- Priority each cycle: `load`, then `en`, then hold.
- On `load`: `x` <= clamp(`load_val`, `lo`, `hi`); state <= `load_dir` ? UP : DOWN; no pulses.
- Degenerate bounds (`lo` >= `hi`) with `en`=1: `x` <= `lo`; state unchanged; no pulses.
- Out-of-range recovery with `en`=1: if `x` < `lo`, then `x` <= `lo`; if `x` > `hi`, then `x` <= `hi`. No state change and no pulse that cycle.
- Bounce, UP:
  - If `x` == `hi`: state <= DOWN, `x` held, `peak`=1 (turnaround cycle).
  - Otherwise `x` <= min(`x`+`step`, `hi`). Compute the sum at WIDTH+1 bits; no wrap.
- Bounce, DOWN:
  - If `x` == `lo`: state <= UP, `x` held, `floor`=1.
  - Otherwise `x` <= max(`x`-`step`, `lo`). Compute with a borrow bit; no underflow.
- Sawtooth, UP:
  - If `x` == `hi`: `x` <= `lo`, `peak`=1, state stays UP.
  - Otherwise step up with clamp as in bounce.
- Sawtooth, DOWN: state <= UP, `x` held, no pulse.
- `mode`, `lo`, `hi` and `step` changes take effect on the next enabled edge. Mid-sweep bound changes are handled by the clamp and recovery rules.
- `peak` and `floor` are registered and never asserted together.

## Timing
- Single-cycle update; `x` reflects the decision made at the same edge.
- Pulses are high for exactly the cycle after the endpoint edge.
- Bounce period, without the macro: 2·ceil((`hi`−`lo`)/`step`) + 2 cycles.
- Sawtooth period: ceil((`hi`−`lo`)/`step`) + 1 cycles.
- Reset asserted mid-sweep: outputs go to reset values asynchronously. The first enabled edge after release sees DOWN at `x`=0.

## Configuration
- `STM_SWEEP_DWELL_EN` defined:
  - In bounce mode, reaching an endpoint enters HOLD for `DWELL` enabled cycles with `x` held.
  - The turnaround (direction flip and pulse) then happens on the following edge.
  - `en`=0 freezes the dwell counter; `load` aborts HOLD.
  - Bounce period increases by 2·`DWELL`. Sawtooth is unaffected.
- Not defined: no HOLD state and no counter; `DWELL` is ignored.

## Test plan
- Reset release, WIDTH=4, `lo`=0, `hi`=15, `step`=1, bounce, `en`=1:
  - `floor` pulses at cycle 1.
  - `x` counts 1..15; `peak` at 15; period 32.
- `lo`=3, `hi`=12, `step`=4, bounce: `x` sequence 3, 7, 11, 12, 12(peak), 8, 4, 3, 3(floor).
- Sawtooth, `lo`=2, `hi`=5, `step`=1: `x` sequence 2, 3, 4, 5, 2 with `peak` on the wrap; period 4.
- `load`=1, `en`=1, `load_val`=14, `hi`=10, `load_dir`=0: `x`=10 and `dir`=0 next cycle, no pulse.
- Reset asserted while `x`=9 in UP: `x`=0, `dir`=0 immediately, without a clock edge.
- Macro defined, `DWELL`=2, `lo`=0, `hi`=3, bounce:
  - `x` holds 3 for 2 extra cycles before `peak`; period 12.
  - `en` low during HOLD extends the hold.
